// File: rtl/rot_regfile_sequencer.sv
// Sequencer for the nibble-serial rotating register file: frame counter,
// two-port round-robin arbitration, write serialisation and read assembly.
module rot_regfile_sequencer #(
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [2:0]           counter,
  output logic [ADDR_BITS-1:0] w_addr,
  output logic                 set_data,
  output logic [3:0]           data_in,
  output logic [ADDR_BITS-1:0] r1_addr,
  input  logic [3:0]           rf_rdata,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic                 a_we,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [31:0]          a_wdata,
  output logic                 a_rvalid,
  input  logic                 a_rready,
  output logic [31:0]          a_rdata,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic                 b_we,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [31:0]          b_wdata,
  output logic                 b_rvalid,
  input  logic                 b_rready,
  output logic [31:0]          b_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t               state, state_next;
  logic                 boundary;
  logic                 a_elig, b_elig;
  logic                 grant_a, grant_b, accept;
  logic                 rr_ptr;   // 0 = A has priority on a tie
  logic                 port_q;   // owner of the current op: 0 = A, 1 = B
  logic                 sel_we;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [31:0]          sel_wdata;
  logic [31:0]          wdata_q;
  logic [27:0]          shadow;
  logic [2:0]           nib_next;

  assign boundary = (counter == 3'd7);
  assign a_elig   = a_valid & (a_we | ~a_rvalid);
  assign b_elig   = b_valid & (b_we | ~b_rvalid);
  assign nib_next = counter + 3'd1;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (boundary) begin
      if (a_elig && b_elig) begin
        grant_a = ~rr_ptr;
        grant_b = rr_ptr;
      end else begin
        grant_a = a_elig;
        grant_b = b_elig;
      end
    end
    accept    = grant_a | grant_b;
    sel_we    = grant_b ? b_we    : a_we;
    sel_addr  = grant_b ? b_addr  : a_addr;
    sel_wdata = grant_b ? b_wdata : a_wdata;
    state_next = state;
    if (boundary) begin
      if (accept) state_next = sel_we ? WRITE : READ;
      else        state_next = IDLE;
    end
  end

  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign set_data = (state == WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state   <= state_next;
      counter <= counter + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= 1'b0;
      port_q  <= 1'b0;
      wdata_q <= '0;
      w_addr  <= '0;
      data_in <= '0;
      r1_addr <= '0;
    end else begin
      if (boundary && a_elig && b_elig) rr_ptr <= ~rr_ptr;
      if (accept) begin
        port_q <= grant_b;
        if (sel_we) begin
          wdata_q <= sel_wdata;
          w_addr  <= sel_addr;
          data_in <= sel_wdata[3:0];
        end else begin
          r1_addr <= sel_addr;
        end
      end else if (state == WRITE && !boundary) begin
        // data_in is registered, so the next nibble is staged one edge early
        data_in <= wdata_q[{nib_next, 2'b00} +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      if (state == READ && !boundary)
        shadow[{counter, 2'b00} +: 4] <= rf_rdata;

      if (state == READ && boundary && !port_q) begin
        a_rdata  <= {rf_rdata, shadow};
        a_rvalid <= 1'b1;
      end else if (a_rvalid && a_rready) begin
        a_rvalid <= 1'b0;
      end

      if (state == READ && boundary && port_q) begin
        b_rdata  <= {rf_rdata, shadow};
        b_rvalid <= 1'b1;
      end else if (b_rvalid && b_rready) begin
        b_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rot_regfile_sequencer.sv
// Directed bench for rot_regfile_sequencer with a behavioural nibble-serial
// register file attached to the write and read-1 ports.
module tb_rot_regfile_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  counter;
  logic [3:0]  w_addr, r1_addr;
  logic        set_data;
  logic [3:0]  data_in, rf_rdata;
  logic        a_valid, a_ready, a_we, a_rvalid, a_rready;
  logic [3:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        b_valid, b_ready, b_we, b_rvalid, b_rready;
  logic [3:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;

  logic [31:0] mem [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rot_regfile_sequencer #(.ADDR_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .counter(counter), .w_addr(w_addr),
    .set_data(set_data), .data_in(data_in), .r1_addr(r1_addr), .rf_rdata(rf_rdata),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rready(a_rready), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rready(b_rready), .b_rdata(b_rdata)
  );

  // Register file model: one nibble per cycle, selected by the frame counter
  always @(posedge clk)
    if (set_data) mem[w_addr][{counter, 2'b00} +: 4] <= data_in;
  assign rf_rdata = mem[r1_addr][{counter, 2'b00} +: 4];

  typedef struct {
    int          port;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
  } op_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_boundary();
    int n = 0;
    while (counter !== 3'd7 && n < 16) begin
      tick();
      n++;
    end
    if (counter !== 3'd7) chk("boundary_timeout", {29'd0, counter}, 32'd7);
  endtask

  task automatic drive(input int port, input logic v, input logic we,
                       input logic [3:0] addr, input logic [31:0] wd);
    if (port == 0) begin
      a_valid = v; a_we = we; a_addr = addr; a_wdata = wd;
    end else begin
      b_valid = v; b_we = we; b_addr = addr; b_wdata = wd;
    end
  endtask

  function automatic logic rvalid_of(input int port);
    return (port == 0) ? a_rvalid : b_rvalid;
  endfunction

  task automatic wait_response(input int port, input logic [31:0] exp, input string tag);
    int lat = 1;
    while (!rvalid_of(port) && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 32'd9);
    chk({tag, "_rdata"}, (port == 0) ? a_rdata : b_rdata, exp);
  endtask

  task automatic consume(input int port, input string tag);
    if (port == 0) a_rready = 1'b1; else b_rready = 1'b1;
    tick();
    a_rready = 1'b0;
    b_rready = 1'b0;
    chk({tag, "_rvalid_clear"}, {31'd0, rvalid_of(port)}, 32'd0);
  endtask

  // Leaves a write at counter==7 of its frame so the next op can be back-to-back
  task automatic run_op(input op_t o, input string tag);
    wait_boundary();
    drive(o.port, 1'b1, o.we, o.addr, o.data);
    #1;
    chk({tag, "_ready_own"},   {31'd0, (o.port == 0) ? a_ready : b_ready}, 32'd1);
    chk({tag, "_ready_other"}, {31'd0, (o.port == 0) ? b_ready : a_ready}, 32'd0);
    tick();
    drive(o.port, 1'b0, 1'b0, 4'd0, 32'd0);
    if (o.we) begin
      for (int k = 0; k < 8; k++) begin
        chk({tag, "_set_data"}, {31'd0, set_data}, 32'd1);
        chk({tag, "_w_addr"},   {28'd0, w_addr}, {28'd0, o.addr});
        chk({tag, "_data_in"},  {28'd0, data_in}, {28'd0, o.data[4*k +: 4]});
        if (k < 7) tick();
      end
    end else begin
      wait_response(o.port, o.data, tag);
      consume(o.port, tag);
    end
  endtask

  op_t ops [8];
  int  bad;

  initial begin
    ops[0] = '{0, 1'b1, 4'd3,  32'h7654_3210};
    ops[1] = '{1, 1'b0, 4'd3,  32'h7654_3210};
    ops[2] = '{1, 1'b1, 4'd10, 32'hDEAD_BEEF};
    ops[3] = '{0, 1'b0, 4'd10, 32'hDEAD_BEEF};
    ops[4] = '{0, 1'b1, 4'd0,  32'hFFFF_FFFF};
    ops[5] = '{1, 1'b1, 4'd15, 32'h0000_000A};
    ops[6] = '{0, 1'b0, 4'd15, 32'h0000_000A};
    ops[7] = '{1, 1'b0, 4'd0,  32'hFFFF_FFFF};

    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst_n = 1'b0;
    a_valid = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_rready = 0;
    b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_rready = 0;

    // Reset values, then counter wrap with no traffic
    #2;
    chk("rst_counter",  {29'd0, counter}, 32'd0);
    chk("rst_set_data", {31'd0, set_data}, 32'd0);
    chk("rst_addrs",    {24'd0, w_addr, r1_addr}, 32'd0);
    chk("rst_data_in",  {28'd0, data_in}, 32'd0);
    chk("rst_ready",    {30'd0, a_ready, b_ready}, 32'd0);
    chk("rst_rvalid",   {30'd0, a_rvalid, b_rvalid}, 32'd0);
    chk("rst_a_rdata",  a_rdata, 32'd0);
    chk("rst_b_rdata",  b_rdata, 32'd0);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("counter_seq", {29'd0, counter}, i % 8);
      if (set_data || a_ready || b_ready || a_rvalid || b_rvalid) bad++;
    end
    chk("idle_quiet", bad, 32'd0);

    // Table-driven ops; entries 0/1 form the write-then-read hazard pair
    for (int i = 0; i < 8; i++) run_op(ops[i], $sformatf("op%0d", i));

    // Round-robin with both ports continuously requesting
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      wait_boundary();
      drive(0, 1'b1, 1'b1, 4'd5, 32'h5555_5555);
      drive(1, 1'b1, 1'b1, 4'd6, 32'h6666_6666);
      #1;
      chk("rr_a_ready", {31'd0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_b_ready", {31'd0, b_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      for (int j = 0; j < 7; j++) begin
        if (a_ready || b_ready) bad++;
        tick();
      end
    end
    drive(0, 1'b0, 1'b0, 4'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 32'd0);
    tick();
    chk("rr_ready_offboundary", bad, 32'd0);
    chk("rr_mem5", mem[5], 32'h5555_5555);
    chk("rr_mem6", mem[6], 32'h6666_6666);

    // Second read from A stalls while the first response is unconsumed
    wait_boundary();
    drive(0, 1'b1, 1'b0, 4'd3, 32'd0);
    #1;
    chk("stall_first_ready", {31'd0, a_ready}, 32'd1);
    tick();
    drive(0, 1'b0, 1'b0, 4'd0, 32'd0);
    wait_response(0, 32'h7654_3210, "stall_r1");
    drive(0, 1'b1, 1'b0, 4'd10, 32'd0);
    wait_boundary();
    #1;
    chk("stall_ready_lo1", {31'd0, a_ready}, 32'd0);
    tick();
    wait_boundary();
    #1;
    chk("stall_ready_lo2", {31'd0, a_ready}, 32'd0);
    chk("stall_rvalid_held", {31'd0, a_rvalid}, 32'd1);
    chk("stall_rdata_held", a_rdata, 32'h7654_3210);
    tick();
    consume(0, "stall_r1");
    wait_boundary();
    #1;
    chk("stall_second_ready", {31'd0, a_ready}, 32'd1);
    tick();
    drive(0, 1'b0, 1'b0, 4'd0, 32'd0);
    wait_response(0, 32'hDEAD_BEEF, "stall_r2");
    consume(0, "stall_r2");

    // Reset in the middle of a write frame
    wait_boundary();
    drive(0, 1'b1, 1'b1, 4'd9, 32'h1234_5678);
    tick();
    drive(0, 1'b0, 1'b0, 4'd0, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("midrst_pre_counter", {29'd0, counter}, 32'd4);
    chk("midrst_pre_set", {31'd0, set_data}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_counter", {29'd0, counter}, 32'd0);
    chk("midrst_set_data", {31'd0, set_data}, 32'd0);
    chk("midrst_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    chk("midrst_w_addr", {28'd0, w_addr}, 32'd0);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (counter !== 3'(i % 8)) bad++;
      if (set_data || a_rvalid || b_rvalid) bad++;
    end
    chk("midrst_resume", bad, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
